demodulator_psk: RTL and testbench

//  Receive end of the PSK/PWM serial link. Recovers 8-bit samples from the serial line
//  (pwm) using the symbol toggle strobe (symb_clk) for frame alignment.

---
 rtl/demodulator_psk.sv | 178 +++++++++++++++++
 tb/tb_demodulator_psk.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/demodulator_psk.sv
// PSK/PWM receive end: frames on symb_clk toggles, votes over repeated symbols, one write strobe 1 clk after frame end.
// Drops the sample (sticky overflow) when full=1; define DEMOD_MAJORITY_EN for per-bit majority vote instead of mid-bit sampling.
module demodulator_psk #(
  parameter int PSK_CLKS_PER_BIT    = 4,
  parameter int PSK_BITS_PER_SYMBOL = 4,
  parameter int PSK_REPEATED_SAMPLE = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pwm,
  input  logic       symb_clk,
  output logic [7:0] wdata,
  output logic       write,
  input  logic       full,
  output logic       locked,
  output logic       err_rep,
  output logic       err_sync,
  output logic       overflow
);

  localparam int CPB = PSK_CLKS_PER_BIT;
  localparam int BPS = PSK_BITS_PER_SYMBOL;
  localparam int REP = PSK_REPEATED_SAMPLE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int RW  = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BPS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

  state_t        state_q;
  logic          symb_q;
  logic [CW-1:0] c_q, c_d, c_now;
  logic [BW-1:0] b_q, b_d, b_now;
  logic [RW-1:0] r_q, r_d, r_now;
  logic [7:0]    cur_q, ref_q, wdata_q, cur_full;
  logic          write_q, locked_q, err_rep_q, err_sync_q, overflow_q;
  logic          tgl, active, bit_end, rep_end, frame_end, bit_val;

  // A toggle always restarts the frame: the toggle cycle is processed as c=b=r=0.
  always_comb begin
    tgl       = symb_clk ^ symb_q;
    active    = tgl || (state_q == S_RUN);
    c_now     = tgl ? '0 : c_q;
    b_now     = tgl ? '0 : b_q;
    r_now     = tgl ? '0 : r_q;
    bit_end   = active && (c_now == C_LAST);
    rep_end   = bit_end && (b_now == B_LAST);
    frame_end = rep_end && (r_now == R_LAST);

    cur_full        = cur_q;
    cur_full[b_now] = bit_val;

    c_d = c_q;
    b_d = b_q;
    r_d = r_q;
    if (active) begin
      c_d = bit_end ? '0 : c_now + CW'(1);
      b_d = b_now;
      r_d = r_now;
      if (bit_end) b_d = rep_end ? '0 : b_now + BW'(1);
      if (rep_end) r_d = frame_end ? '0 : r_now + RW'(1);
    end
  end

`ifdef DEMOD_MAJORITY_EN
  localparam int OW = $clog2(CPB + 1);
  localparam logic [OW-1:0] HALF_ONES = OW'(CPB / 2);

  logic [OW-1:0] ones_q, ones_d, ones_now;

  // Ties resolve to 0 because the comparison is strict.
  always_comb begin
    ones_now = (tgl ? '0 : ones_q) + OW'(pwm);
    bit_val  = (ones_now > HALF_ONES);
    ones_d   = ones_q;
    if (active) ones_d = bit_end ? '0 : ones_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else if (enable) begin
      ones_q <= ones_d;
    end
  end
`else
  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2);

  logic samp_q, samp_d;

  // With CPB=2 the mid-bit sample is also the last cycle, so take pwm directly there.
  always_comb begin
    bit_val = (c_now == C_HALF) ? pwm : samp_q;
    samp_d  = samp_q;
    if (active && (c_now == C_HALF)) samp_d = pwm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 1'b0;
    end else if (enable) begin
      samp_q <= samp_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      symb_q     <= 1'b0;
      c_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      cur_q      <= '0;
      ref_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_rep_q  <= 1'b0;
      err_sync_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (!enable) begin
      write_q <= 1'b0;
    end else begin
      symb_q  <= symb_clk;
      c_q     <= c_d;
      b_q     <= b_d;
      r_q     <= r_d;
      write_q <= 1'b0;

      if (bit_end) cur_q <= cur_full;
      if (rep_end && (r_now == '0)) ref_q <= cur_full;
      if (rep_end && (r_now != '0) && (cur_full != ref_q)) err_rep_q <= 1'b1;
      if (tgl && (state_q == S_RUN)) err_sync_q <= 1'b1;

      // With REP=1 the reference is being captured this same cycle.
      if (frame_end) begin
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          write_q <= 1'b1;
          wdata_q <= (r_now == '0) ? cur_full : ref_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (tgl) begin
            state_q  <= S_RUN;
            locked_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (frame_end) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tgl) state_q <= S_RUN;
        end
        default: begin
          state_q  <= S_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign wdata    = wdata_q;
  assign write    = write_q & enable;
  assign locked   = locked_q;
  assign err_rep  = err_rep_q;
  assign err_sync = err_sync_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_demodulator_psk.sv
// Directed bench for demodulator_psk (CPB=4, BPS=4, REP=2): hand-computed samples, latencies and flags.
module tb_demodulator_psk;
  localparam int CPB = 4;
  localparam int BPS = 4;
  localparam int REP = 2;
  localparam int F   = CPB * BPS * REP;

  logic       clk = 1'b0;
  logic       rst, enable, pwm, symb_clk, full;
  logic [7:0] wdata;
  logic       write, locked, err_rep, err_sync, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int glitch_c = -1;
  int pause_at = -1;
  int pause_len = 0;
  logic [7:0] wd_q[$];
  int         wc_q[$];

  demodulator_psk #(
    .PSK_CLKS_PER_BIT   (CPB),
    .PSK_BITS_PER_SYMBOL(BPS),
    .PSK_REPEATED_SAMPLE(REP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .pwm     (pwm),
    .symb_clk(symb_clk),
    .wdata   (wdata),
    .write   (write),
    .full    (full),
    .locked  (locked),
    .err_rep (err_rep),
    .err_sync(err_sync),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    symb_clk = 1'b0;
    pwm      = 1'b0;
    full     = 1'b0;
    enable   = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives the first ncyc cycles of one frame: copy r=0 carries v0, r=1 carries v1, LSB first.
  task automatic send(input logic [7:0] v0, input logic [7:0] v1, input bit tg, input int ncyc);
    int idx = 0;
    for (int r = 0; r < REP; r++) begin
      for (int b = 0; b < BPS; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (idx < ncyc) begin
            if (idx == pause_at) begin
              repeat (pause_len) begin
                step();
                enable = 1'b0;
                pwm    = 1'($urandom_range(0, 1));
              end
            end
            step();
            enable = 1'b1;
            if (idx == 0) begin
              start_cyc = cyc;
              if (tg) symb_clk = ~symb_clk;
            end
            pwm = ((r == 0) ? v0[b] : v1[b]) ^ (c == glitch_c);
            idx++;
          end
        end
      end
    end
  endtask

  initial begin
    int s1;
    rst = 1'b1; enable = 1'b1; pwm = 1'b0; symb_clk = 1'b0; full = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_write", write, 0);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_flags", {err_rep, err_sync, overflow}, 0);

    // T2: sample with no preceding toggle is discarded
    clr();
    send(8'h05, 8'h05, 1'b0, F);
    step();
    check_eq("t2_nowrite", wd_q.size(), 0);
    check_eq("t2_locked", locked, 0);

    // T1: aligned back-to-back frames
    clr();
    send(8'h05, 8'h05, 1'b1, F);
    s1 = start_cyc;
    send(8'h0A, 8'h0A, 1'b1, F);
    step();
    check_eq("t1_count", wd_q.size(), 2);
    check_eq("t1_data0", wd_q[0], 8'h05);
    check_eq("t1_data1", wd_q[1], 8'h0A);
    check_eq("t1_latency", wc_q[0] - s1, F);
    check_eq("t1_spacing", wc_q[1] - wc_q[0], F);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_err_rep", err_rep, 0);
    step();
    step();
    check_eq("t1_wdata_hold", wdata, 8'h0A);

    // T3: corrupted second copy
    clr();
    send(8'h05, 8'h07, 1'b1, F);
    step();
    check_eq("t3_count", wd_q.size(), 1);
    check_eq("t3_data", wd_q[0], 8'h05);
    check_eq("t3_err_rep", err_rep, 1);
    check_eq("t3_err_sync", err_sync, 0);

    // enable gap mid-frame stretches latency but not content
    clr();
    pause_at  = 10;
    pause_len = 5;
    send(8'h0A, 8'h0A, 1'b1, F);
    step();
    pause_at = -1;
    check_eq("en_data", wd_q[0], 8'h0A);
    check_eq("en_latency", wc_q[0] - start_cyc, F + 5);

    // T4: toggle at c=2,b=1 then a full frame
    do_reset();
    clr();
    send(8'h05, 8'h05, 1'b1, 6);
    send(8'h09, 8'h09, 1'b1, F);
    step();
    check_eq("t4_err_sync", err_sync, 1);
    check_eq("t4_count", wd_q.size(), 1);
    check_eq("t4_data", wd_q[0], 8'h09);
    check_eq("t4_latency", wc_q[0] - start_cyc, F);

    // T5: full during the write cycle
    do_reset();
    clr();
    full = 1'b1;
    send(8'h05, 8'h05, 1'b1, F);
    step();
    full = 1'b0;
    check_eq("t5_nowrite", wd_q.size(), 0);
    check_eq("t5_overflow", overflow, 1);
    send(8'h0A, 8'h0A, 1'b1, F);
    step();
    check_eq("t5_count", wd_q.size(), 1);
    check_eq("t5_data", wd_q[0], 8'h0A);

    // reset mid-frame
    clr();
    send(8'h05, 8'h05, 1'b1, 10);
    step();
    rst = 1'b1;
    symb_clk = 1'b0;
    step();
    rst = 1'b0;
    check_eq("rstmid_flags", {err_rep, err_sync, overflow}, 0);
    check_eq("rstmid_locked", locked, 0);
    check_eq("rstmid_wdata", wdata, 0);
    send(8'h05, 8'h05, 1'b0, F);
    step();
    check_eq("rstmid_nowrite", wd_q.size(), 0);
    check_eq("rstmid_idle", locked, 0);

    // T6: single-cycle glitches inside every bit
    do_reset();
    clr();
    glitch_c = 2;
    send(8'h0C, 8'h0C, 1'b1, F);
    glitch_c = 1;
    send(8'h0C, 8'h0C, 1'b1, F);
    step();
    glitch_c = -1;
    check_eq("t6_count", wd_q.size(), 2);
`ifdef DEMOD_MAJORITY_EN
    check_eq("t6_glitch_c2", wd_q[0], 8'h0C);
`else
    check_eq("t6_glitch_c2", wd_q[0], 8'h03);
`endif
    check_eq("t6_glitch_c1", wd_q[1], 8'h0C);
    check_eq("t6_err_rep", err_rep, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
